xp_switch_alloc: RTL and testbench

Per-router switch allocator for the XP mesh crosspoint. It sits downstream of the per-input X-Y route computation units and consumes each input's `(req_valid, req_port)`. It then arbitrates round-robin among all inputs contending for the same output port, gated by per-output downstream credits. It drives registered grants to the inputs and registered crossbar selects and valids to the outputs.

---
 rtl/coh_noc_pkg.sv | 15 +
 rtl/xp_rr_arbiter.sv | 55 +++++
 rtl/xp_switch_alloc.sv | 143 ++++++++++++++
 tb/tb_xp_switch_alloc.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coh_noc_pkg.sv
// Shared XP mesh definitions used by route compute and the switch allocator.
package coh_noc_pkg;

    typedef enum logic [2:0] {
        PORT_NORTH = 3'd0,
        PORT_SOUTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    localparam int unsigned XP_NUM_PORTS    = 5;
    localparam int unsigned XP_CREDIT_DEPTH = 4;

endpackage

// File: rtl/xp_rr_arbiter.sv
// N-way round-robin arbiter: first request at or above the pointer wins, pointer
// moves past the winner on a grant.
module xp_rr_arbiter #(
    parameter int unsigned N  = 5,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // search ptr, ptr+1, ... wrapping modulo N
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (vld) begin
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xp_switch_alloc.sv
// XP router switch allocator: per-output round-robin with registered grants/selects.
// Define XP_SWALLOC_CREDIT_EN to build downstream credit counters and err_credit_ovf.
module xp_switch_alloc
    import coh_noc_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = XP_NUM_PORTS,
    parameter int unsigned CREDIT_DEPTH = XP_CREDIT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PORTS-1:0]      req_valid,
    input  logic [NUM_PORTS-1:0][2:0] req_port,
    input  logic [NUM_PORTS-1:0]      credit_return,
    output logic [NUM_PORTS-1:0]      grant,
    output logic [NUM_PORTS-1:0]      out_valid,
    output logic [NUM_PORTS-1:0][2:0] xbar_sel,
    output logic                      err_bad_port,
    output logic                      err_credit_ovf
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]                grant_q, grant_d;
    logic [NUM_PORTS-1:0]                out_valid_q, out_valid_d;
    logic [NUM_PORTS-1:0][2:0]           sel_q, sel_d;
    logic                                bad_q, bad_d;
    logic [NUM_PORTS-1:0]                credit_ok;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] elig;     // [output][input]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] arb_gnt;  // [output][input]
    logic [NUM_PORTS-1:0][PW-1:0]        arb_idx;
    logic [NUM_PORTS-1:0]                arb_vld;

    // The registered grant masks an input while it retires the granted flit.
    always_comb begin
        elig = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                elig[o][i] = req_valid[i] && (32'(req_port[i]) == o) &&
                             !grant_q[i] && credit_ok[o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        xp_rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (elig[o]),
            .gnt (arb_gnt[o]),
            .idx (arb_idx[o]),
            .vld (arb_vld[o])
        );
    end

    always_comb begin
        grant_d     = '0;
        out_valid_d = arb_vld;
        sel_d       = sel_q;
        bad_d       = bad_q;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            grant_d = grant_d | arb_gnt[o];
            if (arb_vld[o]) begin
                sel_d[o] = 3'(arb_idx[o]);
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req_valid[i] && (32'(req_port[i]) >= NUM_PORTS)) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= '0;
            out_valid_q <= '0;
            sel_q       <= '0;
            bad_q       <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            bad_q       <= bad_d;
        end
    end

`ifdef XP_SWALLOC_CREDIT_EN
    localparam int unsigned CW = $clog2(CREDIT_DEPTH + 1);

    logic [NUM_PORTS-1:0][CW-1:0] credit_q, credit_d;
    logic                         ovf_q, ovf_d;

    always_comb begin
        credit_ok = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            credit_ok[o] = (credit_q[o] != '0);
        end
    end

    // A grant and a return in the same cycle cancel out.
    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (arb_vld[o] && !credit_return[o]) begin
                credit_d[o] = credit_q[o] - 1'b1;
            end else if (!arb_vld[o] && credit_return[o]) begin
                if (credit_q[o] == CW'(CREDIT_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    credit_d[o] = credit_q[o] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                credit_q[o] <= CW'(CREDIT_DEPTH);
            end
            ovf_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign err_credit_ovf = ovf_q;
`else
    logic credit_return_unused;

    assign credit_return_unused = ^credit_return;
    assign credit_ok            = '1;
    assign err_credit_ovf       = 1'b0;
`endif

    assign grant        = grant_q;
    assign out_valid    = out_valid_q;
    assign xbar_sel     = sel_q;
    assign err_bad_port = bad_q;

endmodule

// File: tb/tb_xp_switch_alloc.sv
// Scoreboard bench for xp_switch_alloc; expectations follow XP_SWALLOC_CREDIT_EN.
module tb_xp_switch_alloc;

    localparam int NP = 5;

    logic                clk;
    logic                rst;
    logic [NP-1:0]       req_valid;
    logic [NP-1:0][2:0]  req_port;
    logic [NP-1:0]       credit_return;
    logic [NP-1:0]       grant;
    logic [NP-1:0]       out_valid;
    logic [NP-1:0][2:0]  xbar_sel;
    logic                err_bad_port;
    logic                err_credit_ovf;

`ifdef XP_SWALLOC_CREDIT_EN
    localparam logic CRED = 1'b1;
`else
    localparam logic CRED = 1'b0;
`endif

    xp_switch_alloc #(.NUM_PORTS(NP), .CREDIT_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_port       (req_port),
        .credit_return  (credit_return),
        .grant          (grant),
        .out_valid      (out_valid),
        .xbar_sel       (xbar_sel),
        .err_bad_port   (err_bad_port),
        .err_credit_ovf (err_credit_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int                 cyc;
        logic [NP-1:0]      g;
        logic [NP-1:0]      ov;
        logic [NP-1:0][2:0] sel;
    } exp_t;

    exp_t               q[$];
    logic [NP-1:0][2:0] exp_sel;
    int                 flits[NP];
    int                 waitc[NP];
    logic [NP-1:0]      auto_ret;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endfunction

    // Expect input i to win output o in cycle c; sel of idle outputs is carried.
    function automatic void exp_add(int c, int i, int o);
        exp_t t;
        exp_sel[o] = 3'(i);
        if (q.size() != 0 && q[q.size()-1].cyc == c) begin
            t = q.pop_back();
        end else begin
            t.cyc = c;
            t.g   = '0;
            t.ov  = '0;
        end
        t.g[i]  = 1'b1;
        t.ov[o] = 1'b1;
        t.sel   = exp_sel;
        q.push_back(t);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (q.size() != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_out at cycle %0d: got no output, expected grant=%b out_valid=%b",
                     e.cyc, e.g, e.ov);
        end
        if (grant != '0 || out_valid != '0) begin
            if (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("grant_ov_sel", {7'b0, grant, out_valid, xbar_sel}, {7'b0, e.g, e.ov, e.sel});
            end else begin
                check("unexpected_out", {22'b0, grant, out_valid}, 32'b0);
            end
        end
    end

    // Upstream model: hold the request through the grant cycle, drop it the
    // cycle after, re-present the next flit one cycle later.
    task automatic cycle();
        @(negedge clk);
        credit_return = out_valid & auto_ret;
        for (int i = 0; i < NP; i++) begin
            if (grant[i] === 1'b1) begin
                if (flits[i] > 0) flits[i]--;
                waitc[i] = 2;
            end else if (waitc[i] > 0) begin
                waitc[i]--;
                req_valid[i] = (waitc[i] == 0) && (flits[i] > 0);
            end
        end
    endtask

    task automatic start(int i, int p, int n);
        req_port[i]  = 3'(p);
        flits[i]     = n;
        waitc[i]     = 0;
        req_valid[i] = 1'b1;
    endtask

    task automatic run_to(int t);
        while (cyc < t) cycle();
    endtask

    task automatic clear_inputs();
        req_valid     = '0;
        req_port      = '0;
        credit_return = '0;
        auto_ret      = '0;
        for (int i = 0; i < NP; i++) begin
            flits[i] = 0;
            waitc[i] = 0;
        end
    endtask

    task automatic do_reset();
        cycle();
        rst = 1'b1;
        clear_inputs();
        cycle();
        cycle();
        rst     = 1'b0;
        exp_sel = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst     = 1'b1;
        exp_sel = '0;
        clear_inputs();
        repeat (3) cycle();
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_xbar_sel", 32'(xbar_sel), 32'd0);
        check("reset_err_bad_port", 32'(err_bad_port), 32'd0);
        check("reset_err_credit_ovf", 32'(err_credit_ovf), 32'd0);
        rst = 1'b0;

        // Single request W -> E.
        cycle();
        c = cyc;
        start(3, 2, 1);
        exp_add(c + 1, 3, 2);
        run_to(c + 5);
        check("single_drained", 32'(q.size()), 32'd0);

        // N, S, L contend for E; rotation 0,1,4 repeating.
        do_reset();
        cycle();
        c = cyc;
        auto_ret = 5'b00100;
        start(0, 2, 3);
        start(1, 2, 3);
        start(4, 2, 3);
        for (int k = 0; k < 3; k++) begin
            exp_add(c + 1 + 3*k, 0, 2);
            exp_add(c + 2 + 3*k, 1, 2);
            exp_add(c + 3 + 3*k, 4, 2);
        end
        run_to(c + 13);
        check("rotate_drained", 32'(q.size()), 32'd0);

        // L -> N until credits run out, then a single return.
        do_reset();
        cycle();
        c = cyc;
        start(4, 0, 6);
        for (int k = 0; k < 4; k++) exp_add(c + 1 + 3*k, 4, 0);
        if (CRED) exp_add(c + 18, 4, 0);
        else begin
            exp_add(c + 13, 4, 0);
            exp_add(c + 16, 4, 0);
        end
        run_to(c + 16);
        credit_return[0] = 1'b1;
        run_to(c + 26);
        check("exhaust_drained", 32'(q.size()), 32'd0);

        // Overflow return on W at full credit, then N->S with a same-cycle
        // grant+return at credit 2, and E->W limited to 4 flits.
        do_reset();
        cycle();
        credit_return[3] = 1'b1;
        cycle();
        check("ovf_set", 32'(err_credit_ovf), 32'(CRED));
        c = cyc;
        start(0, 1, 8);
        start(2, 3, 5);
        if (CRED) begin
            for (int k = 0; k < 4; k++) begin
                exp_add(c + 1 + 3*k, 0, 1);
                exp_add(c + 1 + 3*k, 2, 3);
            end
            exp_add(c + 13, 0, 1);
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_add(c + 1 + 3*k, 0, 1);
                if (k < 5) exp_add(c + 1 + 3*k, 2, 3);
            end
        end
        run_to(c + 6);
        credit_return[1] = 1'b1;
        run_to(c + 26);
        check("credit_drained", 32'(q.size()), 32'd0);
        check("ovf_sticky", 32'(err_credit_ovf), 32'(CRED));
        check("no_bad_port", 32'(err_bad_port), 32'd0);

        // Bad port on input E; W -> N unaffected.
        do_reset();
        cycle();
        c = cyc;
        check("bad_port_clear", 32'(err_bad_port), 32'd0);
        start(2, 5, 1);
        start(3, 0, 2);
        exp_add(c + 1, 3, 0);
        exp_add(c + 4, 3, 0);
        run_to(c + 1);
        check("bad_port_set", 32'(err_bad_port), 32'd1);
        run_to(c + 8);
        req_valid[2] = 1'b0;
        run_to(c + 10);
        check("bad_port_sticky", 32'(err_bad_port), 32'd1);
        check("bad_port_drained", 32'(q.size()), 32'd0);

        // Reset with three grants outstanding; requests re-presented after.
        do_reset();
        check("bad_port_rst", 32'(err_bad_port), 32'd0);
        check("ovf_rst", 32'(err_credit_ovf), 32'd0);
        cycle();
        c = cyc;
        start(0, 2, 5);
        start(1, 2, 5);
        start(4, 0, 5);
        start(3, 1, 5);
        exp_add(c + 1, 0, 2);
        exp_add(c + 1, 4, 0);
        exp_add(c + 1, 3, 1);
        run_to(c + 1);
        rst = 1'b1;
        cycle();
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_xbar_sel", 32'(xbar_sel), 32'd0);
        rst     = 1'b0;
        exp_sel = '0;
        start(0, 2, 3);
        start(1, 2, 3);
        start(4, 0, 1);
        start(3, 1, 1);
        exp_add(c + 3, 0, 2);
        exp_add(c + 3, 4, 0);
        exp_add(c + 3, 3, 1);
        exp_add(c + 4, 1, 2);
        exp_add(c + 6, 0, 2);
        exp_add(c + 7, 1, 2);
        if (!CRED) begin
            exp_add(c + 9, 0, 2);
            exp_add(c + 10, 1, 2);
        end
        run_to(c + 15);
        check("midrst_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
